// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game sequencer and its environment
// (frog movement block, car/VGA drawing logic).
interface game_flow_ctrl_if;
  logic       i_Start;
  logic       i_Frame_Tick;
  logic       i_Has_Collided;
  logic [6:0] i_Score;
  logic [2:0] o_State;
  logic       o_Move_En;
  logic       o_Frog_Reset;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Show_Frog;
  logic       o_Game_Over;

  modport slave (
    input  i_Start, i_Frame_Tick, i_Has_Collided, i_Score,
    output o_State, o_Move_En, o_Frog_Reset, o_Lives, o_Level, o_Show_Frog, o_Game_Over
  );

  modport master (
    output i_Start, i_Frame_Tick, i_Has_Collided, i_Score,
    input  o_State, o_Move_En, o_Frog_Reset, o_Lives, o_Level, o_Show_Frog, o_Game_Over
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Frog game sequencer: play/death/level-up/game-over flow, lives, level,
// frog respawn requests and blink visibility. All outputs registered.
module game_flow_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int SCORE_PER_LEVEL = 5,
  parameter int MAX_LEVEL       = 7,
  parameter int DEATH_FRAMES    = 60,
  parameter int LEVELUP_FRAMES  = 90,
  parameter int GAMEOVER_FRAMES = 180,
  parameter int BLINK_FRAMES    = 8
) (
  input logic             i_Clk,
  input logic             i_Rst_L,
  game_flow_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLAY      = 3'd1;
  localparam logic [2:0] ST_DEATH     = 3'd2;
  localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic [1:0] LIVES_C   = 2'(LIVES_INIT);
  localparam logic [6:0] GOALS_C   = 7'(SCORE_PER_LEVEL);
  localparam logic [3:0] MAX_LVL_C = 4'(MAX_LEVEL);
  localparam logic [7:0] DEATH_N   = 8'(DEATH_FRAMES);
  localparam logic [7:0] LVLUP_N   = 8'(LEVELUP_FRAMES);
  localparam logic [7:0] GOVER_N   = 8'(GAMEOVER_FRAMES);
  localparam logic [7:0] BLINK_N   = 8'(BLINK_FRAMES);

  logic [2:0] state_q, state_d;
  logic       move_en_q, move_en_d;
  logic       frog_reset_q, frog_reset_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic       show_q, show_d;
  logic       game_over_q, game_over_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] blink_q, blink_d;
  logic [6:0] goal_cnt_q, goal_cnt_d;
  logic       start_low_q;
  logic [6:0] score_prev_q;

  logic       start_edge, goal, tick, blink_wrap;
  logic [7:0] timer_inc;

  // start_low_q clears on reset, so a switch held through reset must be
  // released before it can start a game.
  assign start_edge = bus.i_Start & start_low_q;
  assign goal       = (state_q == ST_PLAY) && (bus.i_Score == score_prev_q + 7'd1);
  assign tick       = bus.i_Frame_Tick;
  assign timer_inc  = timer_q + 8'd1;
  assign blink_wrap = (state_q == ST_DEATH) && tick && (blink_q + 8'd1 == BLINK_N);

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    goal_cnt_d   = goal_cnt_q;
    frog_reset_d = 1'b0;
    timer_d      = tick ? timer_inc : timer_q;
    blink_d      = blink_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d      = ST_PLAY;
          lives_d      = LIVES_C;
          level_d      = 4'd0;
          goal_cnt_d   = 7'd0;
          frog_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.i_Has_Collided) begin
          state_d      = ST_DEATH;
          lives_d      = lives_q - 2'd1;
          frog_reset_d = 1'b1;
        end else if (goal) begin
          if (goal_cnt_q + 7'd1 == GOALS_C) begin
            state_d    = ST_LEVEL_UP;
            goal_cnt_d = 7'd0;
            level_d    = (level_q < MAX_LVL_C) ? level_q + 4'd1 : level_q;
          end else begin
            goal_cnt_d = goal_cnt_q + 7'd1;
          end
        end
      end
      ST_DEATH: begin
        if (tick) begin
          blink_d = blink_wrap ? 8'd0 : blink_q + 8'd1;
          if (timer_inc == DEATH_N)
            state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_PLAY;
        end
      end
      ST_LEVEL_UP: begin
        if (tick && timer_inc == LVLUP_N) begin
          state_d      = ST_PLAY;
          frog_reset_d = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (tick && timer_inc == GOVER_N) begin
          state_d = ST_IDLE;
          level_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_d = 8'd0;
      blink_d = 8'd0;
    end

    move_en_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_GAME_OVER);
    case (state_d)
      ST_PLAY, ST_LEVEL_UP: show_d = 1'b1;
      ST_DEATH:             show_d = (state_q == ST_DEATH) ? (show_q ^ blink_wrap) : 1'b0;
      default:              show_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      move_en_q    <= 1'b0;
      frog_reset_q <= 1'b0;
      lives_q      <= 2'd0;
      level_q      <= 4'd0;
      show_q       <= 1'b0;
      game_over_q  <= 1'b0;
      timer_q      <= 8'd0;
      blink_q      <= 8'd0;
      goal_cnt_q   <= 7'd0;
      start_low_q  <= 1'b0;
      score_prev_q <= 7'd0;
    end else begin
      state_q      <= state_d;
      move_en_q    <= move_en_d;
      frog_reset_q <= frog_reset_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      show_q       <= show_d;
      game_over_q  <= game_over_d;
      timer_q      <= timer_d;
      blink_q      <= blink_d;
      goal_cnt_q   <= goal_cnt_d;
      start_low_q  <= ~bus.i_Start;
      score_prev_q <= bus.i_Score;
    end
  end

  assign bus.o_State      = state_q;
  assign bus.o_Move_En    = move_en_q;
  assign bus.o_Frog_Reset = frog_reset_q;
  assign bus.o_Lives      = lives_q;
  assign bus.o_Level      = level_q;
  assign bus.o_Show_Frog  = show_q;
  assign bus.o_Game_Over  = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed game scenarios, a behavioural game model
// checked every cycle, plus hand-computed literal expectations.
module tb_game_flow_ctrl;
  localparam int LIVES_INIT      = 3;
  localparam int SCORE_PER_LEVEL = 5;
  localparam int MAX_LEVEL       = 7;
  localparam int DEATH_FRAMES    = 60;
  localparam int LEVELUP_FRAMES  = 90;
  localparam int GAMEOVER_FRAMES = 180;
  localparam int BLINK_FRAMES    = 8;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;
  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .LIVES_INIT(LIVES_INIT), .SCORE_PER_LEVEL(SCORE_PER_LEVEL), .MAX_LEVEL(MAX_LEVEL),
    .DEATH_FRAMES(DEATH_FRAMES), .LEVELUP_FRAMES(LEVELUP_FRAMES),
    .GAMEOVER_FRAMES(GAMEOVER_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .bus(bus)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  int sc       = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: state 0..4, tick count since state entry, goal tally.
  int m_state, m_lives, m_level, m_goals, m_ticks, m_prev_score;
  bit m_armed, m_frog_reset;

  always @(posedge i_Clk or negedge i_Rst_L) begin : model
    int st, lv, lvl, gl, tk, limit;
    bit fr, start_ev, goal_ev;
    if (!i_Rst_L) begin
      m_state <= 0; m_lives <= 0; m_level <= 0; m_goals <= 0; m_ticks <= 0;
      m_prev_score <= 0; m_armed <= 1'b0; m_frog_reset <= 1'b0;
    end else begin
      st = m_state; lv = m_lives; lvl = m_level; gl = m_goals; tk = m_ticks; fr = 1'b0;
      start_ev = bus.i_Start && m_armed;
      goal_ev  = (m_state == 1) && (int'(bus.i_Score) == (m_prev_score + 1) % 128);
      case (m_state)
        0: if (start_ev) begin st = 1; lv = LIVES_INIT; lvl = 0; gl = 0; fr = 1'b1; end
        1: begin
          if (bus.i_Has_Collided) begin st = 2; lv = lv - 1; fr = 1'b1; end
          else if (goal_ev) begin
            gl = gl + 1;
            if (gl == SCORE_PER_LEVEL) begin
              st = 3; gl = 0; lvl = (lvl + 1 > MAX_LEVEL) ? MAX_LEVEL : lvl + 1;
            end
          end
        end
        default: begin
          limit = (m_state == 2) ? DEATH_FRAMES : (m_state == 3) ? LEVELUP_FRAMES : GAMEOVER_FRAMES;
          if (bus.i_Frame_Tick) begin
            tk = tk + 1;
            if (tk == limit) begin
              if (m_state == 2) st = (lv == 0) ? 4 : 1;
              else if (m_state == 3) begin st = 1; fr = 1'b1; end
              else begin st = 0; lvl = 0; end
            end
          end
        end
      endcase
      if (st != m_state) tk = 0;
      m_state <= st; m_lives <= lv; m_level <= lvl; m_goals <= gl; m_ticks <= tk;
      m_frog_reset <= fr;
      m_prev_score <= int'(bus.i_Score);
      m_armed <= !bus.i_Start;
    end
  end

  function automatic int exp_show();
    if (m_state == 1 || m_state == 3) return 1;
    if (m_state == 2) return (m_ticks / BLINK_FRAMES) % 2;
    return 0;
  endfunction

  always @(negedge i_Clk) begin
    if (cmp_en) begin
      chk("state",      int'(bus.o_State),      m_state);
      chk("move_en",    int'(bus.o_Move_En),    (m_state == 1) ? 1 : 0);
      chk("frog_reset", int'(bus.o_Frog_Reset), int'(m_frog_reset));
      chk("lives",      int'(bus.o_Lives),      m_lives);
      chk("level",      int'(bus.o_Level),      m_level);
      chk("show_frog",  int'(bus.o_Show_Frog),  exp_show());
      chk("game_over",  int'(bus.o_Game_Over),  (m_state == 4) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Returns just after the edge that sampled the last tick; gaps vary.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (i % 3) step();
      bus.i_Frame_Tick = 1'b1;
      step();
      bus.i_Frame_Tick = 1'b0;
    end
  endtask

  task automatic goal();
    sc = (sc + 1) % 128;
    bus.i_Score = 7'(sc);
    step();
    step();
  endtask

  task automatic collide();
    bus.i_Has_Collided = 1'b1;
    step();
    bus.i_Has_Collided = 1'b0;
  endtask

  initial begin
    bus.i_Start = 1'b0; bus.i_Frame_Tick = 1'b0; bus.i_Has_Collided = 1'b0; bus.i_Score = 7'd0;
    step();
    cmp_en = 1'b1;
    step(); step();
    chk("rst_state", int'(bus.o_State), 0);
    chk("rst_lives", int'(bus.o_Lives), 0);
    chk("rst_show",  int'(bus.o_Show_Frog), 0);

    i_Rst_L = 1'b1;
    step();
    bus.i_Start = 1'b1; step();
    $display("start pulse: state=%0d lives=%0d", bus.o_State, bus.o_Lives);
    chk("start_state", int'(bus.o_State), 1);
    chk("start_lives", int'(bus.o_Lives), 3);
    chk("start_level", int'(bus.o_Level), 0);
    chk("start_frst",  int'(bus.o_Frog_Reset), 1);
    chk("start_move",  int'(bus.o_Move_En), 1);
    bus.i_Start = 1'b0; step();
    chk("frst_one_cycle", int'(bus.o_Frog_Reset), 0);

    repeat (4) goal();
    chk("four_goals_play", int'(bus.o_State), 1);
    goal();
    $display("fifth goal: state=%0d level=%0d", bus.o_State, bus.o_Level);
    chk("lvlup_state", int'(bus.o_State), 3);
    chk("lvlup_level", int'(bus.o_Level), 1);
    chk("lvlup_move",  int'(bus.o_Move_En), 0);
    ticks(89);
    chk("lvlup_89", int'(bus.o_State), 3);
    ticks(1);
    chk("lvlup_exit_state", int'(bus.o_State), 1);
    chk("lvlup_exit_frst",  int'(bus.o_Frog_Reset), 1);

    // collision and goal in the same cycle
    sc = (sc + 1) % 128; bus.i_Score = 7'(sc);
    collide();
    $display("collision+goal: state=%0d lives=%0d level=%0d", bus.o_State, bus.o_Lives, bus.o_Level);
    chk("coll_state", int'(bus.o_State), 2);
    chk("coll_lives", int'(bus.o_Lives), 2);
    chk("coll_level", int'(bus.o_Level), 1);
    chk("coll_show",  int'(bus.o_Show_Frog), 0);
    ticks(8);
    chk("blink_8", int'(bus.o_Show_Frog), 1);
    ticks(8);
    chk("blink_16", int'(bus.o_Show_Frog), 0);
    ticks(44);
    chk("death_exit_state", int'(bus.o_State), 1);
    chk("death_exit_show",  int'(bus.o_Show_Frog), 1);
    repeat (4) goal();
    chk("goal_cnt_kept", int'(bus.o_State), 1);
    goal();
    chk("lvl2_level", int'(bus.o_Level), 2);
    ticks(LEVELUP_FRAMES);

    collide();
    chk("coll2_lives", int'(bus.o_Lives), 1);
    ticks(DEATH_FRAMES);
    collide();
    chk("coll3_lives", int'(bus.o_Lives), 0);
    ticks(59);
    chk("death3_59", int'(bus.o_State), 2);
    ticks(1);
    $display("third death timeout: state=%0d game_over=%0d", bus.o_State, bus.o_Game_Over);
    chk("go_state", int'(bus.o_State), 4);
    chk("go_flag",  int'(bus.o_Game_Over), 1);
    chk("go_level", int'(bus.o_Level), 2);
    bus.i_Start = 1'b1; step(); bus.i_Start = 1'b0; step();
    chk("go_start_ignored", int'(bus.o_State), 4);
    ticks(GAMEOVER_FRAMES);
    chk("go_exit_state", int'(bus.o_State), 0);
    chk("go_exit_level", int'(bus.o_Level), 0);

    // start held through reset release
    bus.i_Start = 1'b1; i_Rst_L = 1'b0;
    step(); step();
    i_Rst_L = 1'b1;
    repeat (3) step();
    chk("held_start_idle", int'(bus.o_State), 0);
    bus.i_Start = 1'b0; step();
    bus.i_Start = 1'b1; step();
    chk("repress_state", int'(bus.o_State), 1);
    bus.i_Start = 1'b0;

    // score wrap 127 -> 0 counts as a goal
    sc = 127; bus.i_Score = 7'd127; step(); step();
    repeat (5) goal();
    chk("wrap_lvlup", int'(bus.o_State), 3);
    ticks(LEVELUP_FRAMES);
    for (int l = 0; l < 6; l++) begin
      repeat (5) goal();
      ticks(LEVELUP_FRAMES);
    end
    chk("max_level", int'(bus.o_Level), 7);
    repeat (5) goal();
    $display("goals at max level: state=%0d level=%0d", bus.o_State, bus.o_Level);
    chk("sat_state", int'(bus.o_State), 3);
    chk("sat_level", int'(bus.o_Level), 7);
    ticks(10);
    #2;
    i_Rst_L = 1'b0;
    #1;
    chk("async_state", int'(bus.o_State), 0);
    chk("async_move",  int'(bus.o_Move_En), 0);
    chk("async_frst",  int'(bus.o_Frog_Reset), 0);
    chk("async_lives", int'(bus.o_Lives), 0);
    chk("async_level", int'(bus.o_Level), 0);
    chk("async_show",  int'(bus.o_Show_Frog), 0);
    chk("async_go",    int'(bus.o_Game_Over), 0);
    step(); step();
    i_Rst_L = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
